// File: rtl/bilinear_pkg.sv
// Shared types and constants for the bilinear scaler sequencer.
package bilinear_pkg;

  localparam int FRAC_W        = 8;
  localparam int DIV_ITERS     = 17;
  localparam int FLOPS_PER_PIX = 6;
  localparam int RD_PER_PIX    = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DIV,
    S_ROW,
    S_RD00,
    S_RD01,
    S_RD10,
    S_RD11,
    S_CAP,
    S_CALC,
    S_WR,
    S_DONE,
    S_ERR
  } bseq_state_e;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] h;
    logic [15:0] scale;
  } bseq_cfg_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/bilinear_seq_ctrl_if.sv
// Job control, config, BRAM and status bundle between the sequencer and the JTAG/BRAM side.
interface bilinear_seq_ctrl_if #(
  parameter int AW = 12
);
  logic          start;
  logic [15:0]   cfg_in_w;
  logic [15:0]   cfg_in_h;
  logic [15:0]   cfg_scale_q88;
  logic [AW-1:0] in_mem_raddr;
  logic [7:0]    in_mem_rdata;
  logic [AW-1:0] out_mem_waddr;
  logic [7:0]    out_mem_wdata;
  logic          out_mem_we;
  logic          status_done;
  logic          status_busy;
  logic          status_error;
  logic [31:0]   perf_flops;
  logic [31:0]   perf_mem_rd;
  logic [31:0]   perf_mem_wr;

  modport master (
    input  start, cfg_in_w, cfg_in_h, cfg_scale_q88, in_mem_rdata,
    output in_mem_raddr, out_mem_waddr, out_mem_wdata, out_mem_we,
    output status_done, status_busy, status_error,
    output perf_flops, perf_mem_rd, perf_mem_wr
  );

  modport slave (
    output start, cfg_in_w, cfg_in_h, cfg_scale_q88, in_mem_rdata,
    input  in_mem_raddr, out_mem_waddr, out_mem_wdata, out_mem_we,
    input  status_done, status_busy, status_error,
    input  perf_flops, perf_mem_rd, perf_mem_wr
  );
endinterface

// File: rtl/bilinear_interp.sv
// Combinational bilinear blend of four neighbours with FRAC-bit weights; truncating.
module bilinear_interp
  import bilinear_pkg::*;
#(
  parameter int FRAC = FRAC_W
) (
  input  logic [7:0]      p00,
  input  logic [7:0]      p01,
  input  logic [7:0]      p10,
  input  logic [7:0]      p11,
  input  logic [FRAC-1:0] fx,
  input  logic [FRAC-1:0] fy,
  output logic [7:0]      pix
);
  localparam int TW   = 8 + FRAC + 1;
  localparam int ACCW = 8 + 2*FRAC + 1;

  logic [FRAC:0]   wx0, wx1, wy0, wy1;
  logic [TW-1:0]   top, bot;
  logic [ACCW-1:0] acc;

  always_comb begin
    wx1 = {1'b0, fx};
    wy1 = {1'b0, fy};
    wx0 = {1'b1, {FRAC{1'b0}}} - wx1;
    wy0 = {1'b1, {FRAC{1'b0}}} - wy1;
    top = TW'(p00) * TW'(wx0) + TW'(p01) * TW'(wx1);
    bot = TW'(p10) * TW'(wx0) + TW'(p11) * TW'(wx1);
    acc = ACCW'(top) * ACCW'(wy0) + ACCW'(bot) * ACCW'(wy1);
    pix = acc[2*FRAC +: 8];
  end
endmodule

// File: rtl/bilinear_seq_ctrl.sv
// Bilinear scaler sequencer: latch cfg, serial 1/scale divide, per-pixel 4-tap fetch, blend, write.
// Define BSEQ_PERF_EN to build the saturating perf counters; otherwise the perf outputs read 0.
module bilinear_seq_ctrl
  import bilinear_pkg::*;
#(
  parameter int AW   = 12,
  parameter int FRAC = FRAC_W
) (
  input  logic                clk_sys,
  input  logic                rst_sys_n,
  bilinear_seq_ctrl_if.master bus
);
  localparam int CW  = AW + 1;
  localparam int SW  = CW + DIV_ITERS;
  localparam int IW  = SW - FRAC;
  localparam int DCW = $clog2(DIV_ITERS);
  localparam logic [63:0] MAX_PIX = 64'(1) << AW;

  bseq_state_e state, state_nxt;
  bseq_cfg_t   cfg_q;

  logic           start_q, start_edge, accept, cfg_bad, out_bad;
  logic [31:0]    in_area, ow_full, oh_full;
  logic [63:0]    out_area;
  logic [CW-1:0]  out_w, out_h, ox, oy;
  logic           last_col, last_row;
  logic [DCW-1:0] div_cnt;
  logic           div_last, q_bit;
  logic [15:0]    rem, rem_nxt;
  logic [16:0]    rem_sh, inv;
  logic [SW-1:0]  sx, sx_src, sy;
  logic [15:0]    w_lim, h_lim, x0, x1, y0, y1;
  logic [AW-1:0]  b0, b1, b0_c, b1_c, raddr, raddr_nxt, out_idx;
  logic           raddr_ld;
  logic [FRAC-1:0] fy;
  logic [7:0]     p00, p01, p10, p11, pix_c, pix_q;
  logic           busy, done, error, we;

  function automatic logic [15:0] clamp_idx(input logic [IW-1:0] ip, input logic [15:0] lim);
    return (64'(ip) > 64'(lim)) ? lim : 16'(ip);
  endfunction

  // Start is a level held for several cycles; only its rising edge counts.
  assign start_edge = bus.start & ~start_q;
  assign accept     = start_edge & (state == S_IDLE || state == S_DONE || state == S_ERR);

  assign in_area = 32'(bus.cfg_in_w) * 32'(bus.cfg_in_h);
  assign cfg_bad = (bus.cfg_scale_q88 == 16'd0) || (bus.cfg_in_w == 16'd0) ||
                   (bus.cfg_in_h == 16'd0) || (64'(in_area) > MAX_PIX);

  assign ow_full  = (32'(cfg_q.w) * 32'(cfg_q.scale)) >> FRAC;
  assign oh_full  = (32'(cfg_q.h) * 32'(cfg_q.scale)) >> FRAC;
  assign out_area = 64'(ow_full) * 64'(oh_full);
  assign out_bad  = (ow_full == 32'd0) || (oh_full == 32'd0) || (out_area > MAX_PIX);
  assign out_w    = ow_full[CW-1:0];
  assign out_h    = oh_full[CW-1:0];
  assign last_col = (ox == out_w - CW'(1));
  assign last_row = (oy == out_h - CW'(1));

  // Restoring divide of 2^16 by scale: the dividend's single set bit is fed on the first pass.
  assign div_last = (div_cnt == DCW'(DIV_ITERS - 1));
  assign rem_sh   = {rem, (div_cnt == '0)};
  assign q_bit    = (rem_sh >= {1'b0, cfg_q.scale});
  assign rem_nxt  = q_bit ? 16'(rem_sh - {1'b0, cfg_q.scale}) : rem_sh[15:0];

  // Coordinates; during WR the x taps are for the next pixel, so look one step ahead.
  assign w_lim  = cfg_q.w - 16'd1;
  assign h_lim  = cfg_q.h - 16'd1;
  assign sy     = SW'(oy) * SW'(inv);
  assign y0     = clamp_idx(sy[SW-1:FRAC], h_lim);
  assign y1     = (y0 == h_lim) ? y0 : y0 + 16'd1;
  assign sx_src = (state == S_WR) ? sx + SW'(inv) : sx;
  assign x0     = clamp_idx(sx_src[SW-1:FRAC], w_lim);
  assign x1     = (x0 == w_lim) ? x0 : x0 + 16'd1;
  assign b0_c   = AW'(32'(y0) * 32'(cfg_q.w));
  assign b1_c   = AW'(32'(y1) * 32'(cfg_q.w));

  always_comb begin
    raddr_ld  = 1'b1;
    raddr_nxt = raddr;
    case (state)
      S_ROW:  raddr_nxt = b0_c + AW'(x0);
      S_RD00: raddr_nxt = b0 + AW'(x1);
      S_RD01: raddr_nxt = b1 + AW'(x0);
      S_RD10: raddr_nxt = b1 + AW'(x1);
      S_WR: begin
        raddr_ld  = ~last_col;
        raddr_nxt = b0 + AW'(x0);
      end
      default: raddr_ld = 1'b0;
    endcase
  end

  bilinear_interp #(.FRAC(FRAC)) u_interp (
    .p00 (p00),
    .p01 (p01),
    .p10 (p10),
    .p11 (p11),
    .fx  (sx_src[FRAC-1:0]),
    .fy  (fy),
    .pix (pix_c)
  );

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (accept) state_nxt = cfg_bad ? S_ERR : S_DIV;
      S_DIV:  if (div_last) state_nxt = out_bad ? S_ERR : S_ROW;
      S_ROW:  state_nxt = S_RD00;
      S_RD00: state_nxt = S_RD01;
      S_RD01: state_nxt = S_RD10;
      S_RD10: state_nxt = S_RD11;
      S_RD11: state_nxt = S_CAP;
      S_CAP:  state_nxt = S_CALC;
      S_CALC: state_nxt = S_WR;
      S_WR:   state_nxt = !last_col ? S_RD00 : (last_row ? S_DONE : S_ROW);
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    error = 1'b0;
    we    = 1'b0;
    case (state)
      S_DIV, S_ROW, S_RD00, S_RD01, S_RD10, S_RD11, S_CAP, S_CALC: busy = 1'b1;
      S_WR:   begin busy = 1'b1; we = 1'b1; end
      S_DONE: done = 1'b1;
      S_ERR:  begin done = 1'b1; error = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      start_q <= 1'b0;
      cfg_q   <= '0;
      div_cnt <= '0;
      rem     <= '0;
      inv     <= '0;
      ox      <= '0;
      oy      <= '0;
      sx      <= '0;
      b0      <= '0;
      b1      <= '0;
      fy      <= '0;
      p00     <= '0;
      p01     <= '0;
      p10     <= '0;
      p11     <= '0;
      pix_q   <= '0;
      out_idx <= '0;
      raddr   <= '0;
    end else begin
      start_q <= bus.start;
      if (raddr_ld) raddr <= raddr_nxt;
      if (accept) begin
        cfg_q   <= '{w: bus.cfg_in_w, h: bus.cfg_in_h, scale: bus.cfg_scale_q88};
        div_cnt <= '0;
        rem     <= '0;
        inv     <= '0;
        ox      <= '0;
        oy      <= '0;
        sx      <= '0;
        out_idx <= '0;
      end
      case (state)
        S_DIV: begin
          div_cnt <= div_cnt + DCW'(1);
          rem     <= rem_nxt;
          inv     <= {inv[15:0], q_bit};
        end
        S_ROW: begin
          b0 <= b0_c;
          b1 <= b1_c;
          fy <= sy[FRAC-1:0];
        end
        S_RD01: p00   <= bus.in_mem_rdata;
        S_RD10: p01   <= bus.in_mem_rdata;
        S_RD11: p10   <= bus.in_mem_rdata;
        S_CAP:  p11   <= bus.in_mem_rdata;
        S_CALC: pix_q <= pix_c;
        S_WR: begin
          out_idx <= out_idx + AW'(1);
          if (last_col) begin
            ox <= '0;
            sx <= '0;
            oy <= oy + CW'(1);
          end else begin
            ox <= ox + CW'(1);
            sx <= sx_src;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_mem_raddr  = raddr;
  assign bus.out_mem_waddr = out_idx;
  assign bus.out_mem_wdata = pix_q;
  assign bus.out_mem_we    = we;
  assign bus.status_done   = done;
  assign bus.status_busy   = busy;
  assign bus.status_error  = error;

`ifdef BSEQ_PERF_EN
  logic [31:0] flops_q, rd_q, wr_q;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      flops_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else if (accept) begin
      flops_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      if (state == S_CALC) flops_q <= sat_add(flops_q, 32'(FLOPS_PER_PIX));
      if (state == S_RD00 || state == S_RD01 || state == S_RD10 || state == S_RD11)
        rd_q <= sat_add(rd_q, 32'd1);
      if (state == S_WR) wr_q <= sat_add(wr_q, 32'd1);
    end
  end

  assign bus.perf_flops  = flops_q;
  assign bus.perf_mem_rd = rd_q;
  assign bus.perf_mem_wr = wr_q;
`else
  assign bus.perf_flops  = '0;
  assign bus.perf_mem_rd = '0;
  assign bus.perf_mem_wr = '0;
`endif

endmodule

// File: tb/tb_bilinear_seq_ctrl.sv
// Directed + randomized bench for bilinear_seq_ctrl against a floating-free arithmetic reference.
module tb_bilinear_seq_ctrl;
  localparam int AW = 12;

  logic clk_sys   = 1'b0;
  logic rst_sys_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  bilinear_seq_ctrl_if #(.AW(AW)) bus ();

  bilinear_seq_ctrl #(.AW(AW), .FRAC(8)) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .bus       (bus)
  );

  logic [7:0] img [0:(1<<AW)-1];
  always @(posedge clk_sys) bus.in_mem_rdata <= img[bus.in_mem_raddr];

  int wa_q[$];
  int wd_q[$];
  always @(negedge clk_sys) if (bus.out_mem_we === 1'b1) begin
    wa_q.push_back(int'(bus.out_mem_waddr));
    wd_q.push_back(int'(bus.out_mem_wdata));
  end

  int checks = 0;
  int errors = 0;
  int exp_pix[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: evaluates the scaling rules pixel by pixel with integer arithmetic.
  task automatic model(input int w, input int h, input int sc, output int ek, output int ow, output int oh);
    longint inv, sx, sy, x0, x1, y0, y1, fx, fy, top, bot;
    exp_pix.delete();
    ek = 0; ow = 0; oh = 0;
    if (sc == 0 || w == 0 || h == 0 || longint'(w) * h > 4096) begin ek = 1; return; end
    inv = 65536 / sc;
    ow  = (w * sc) / 256;
    oh  = (h * sc) / 256;
    if (ow == 0 || oh == 0 || longint'(ow) * oh > 4096) begin ek = 2; return; end
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        sy = oy * inv;  sx = ox * inv;
        y0 = sy / 256;  if (y0 > h - 1) y0 = h - 1;
        x0 = sx / 256;  if (x0 > w - 1) x0 = w - 1;
        y1 = (y0 + 1 < h) ? y0 + 1 : h - 1;
        x1 = (x0 + 1 < w) ? x0 + 1 : w - 1;
        fy = sy % 256;  fx = sx % 256;
        top = img[y0*w + x0] * (256 - fx) + img[y0*w + x1] * fx;
        bot = img[y1*w + x0] * (256 - fx) + img[y1*w + x1] * fx;
        exp_pix.push_back(int'((top * (256 - fy) + bot * fy) / 65536));
      end
    end
  endtask

  task automatic run_job(input string tag, input int w, input int h, input int sc, input bit poke);
    int ek, ow, oh, exp_cyc, n, gaps, nw, ne;
    bit seen, pe;
`ifdef BSEQ_PERF_EN
    pe = 1'b1;
`else
    pe = 1'b0;
`endif
    model(w, h, sc, ek, ow, oh);
    exp_cyc = (ek == 1) ? 1 : (ek == 2) ? 18 : 17 + oh * (1 + 7 * ow) + 1;
    @(negedge clk_sys);
    wa_q.delete();
    wd_q.delete();
    bus.cfg_in_w      = 16'(w);
    bus.cfg_in_h      = 16'(h);
    bus.cfg_scale_q88 = 16'(sc);
    bus.start         = 1'b1;
    n = 0; gaps = 0; seen = 1'b0;
    while (!seen && n < exp_cyc + 64) begin
      @(posedge clk_sys);
      n++;
      @(negedge clk_sys);
      if (n == 2) begin
        bus.start         = 1'b0;
        bus.cfg_in_w      = 16'($urandom);
        bus.cfg_in_h      = 16'($urandom);
        bus.cfg_scale_q88 = 16'($urandom);
      end
      if (poke && n == 100)         bus.start = 1'b1;
      if (poke && n == 101)         bus.start = 1'b0;
      if (poke && n == exp_cyc - 1) bus.start = 1'b1;
      if (bus.status_done === 1'b1) seen = 1'b1;
      else if (bus.status_busy !== 1'b1) gaps++;
    end
    ne = exp_pix.size();
    nw = wa_q.size();
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " cycles"}, 64'(n), 64'(exp_cyc));
    chk({tag, " error"}, 64'(bus.status_error), 64'(ek != 0));
    chk({tag, " busy_gaps"}, 64'(gaps), 64'd0);
    chk({tag, " writes"}, 64'(nw), 64'(ne));
    for (int i = 0; i < nw && i < ne; i++) begin
      chk({tag, " waddr"}, 64'(wa_q[i]), 64'(i));
      chk({tag, " wdata"}, 64'(wd_q[i]), 64'(exp_pix[i]));
    end
    chk({tag, " perf_flops"}, 64'(bus.perf_flops), pe ? 64'(6 * ne) : 64'd0);
    chk({tag, " perf_mem_rd"}, 64'(bus.perf_mem_rd), pe ? 64'(4 * ne) : 64'd0);
    chk({tag, " perf_mem_wr"}, 64'(bus.perf_mem_wr), pe ? 64'(ne) : 64'd0);
    repeat (3) @(negedge clk_sys);
    chk({tag, " done_held"}, 64'(bus.status_done), 64'd1);
    chk({tag, " busy_after"}, 64'(bus.status_busy), 64'd0);
    chk({tag, " no_late_wr"}, 64'(wa_q.size()), 64'(nw));
    bus.start = 1'b0;
  endtask

  initial begin
    int nw, w, h, sc;
    logic [7:0] ramp [4];
    ramp = '{8'd0, 8'd100, 8'd200, 8'd250};
    bus.start = 1'b0;
    bus.cfg_in_w = '0;
    bus.cfg_in_h = '0;
    bus.cfg_scale_q88 = '0;
    for (int i = 0; i < (1 << AW); i++) img[i] = 8'h00;

    repeat (3) @(negedge clk_sys);
    chk("rst done", 64'(bus.status_done), 64'd0);
    chk("rst busy", 64'(bus.status_busy), 64'd0);
    chk("rst error", 64'(bus.status_error), 64'd0);
    chk("rst we", 64'(bus.out_mem_we), 64'd0);
    chk("rst raddr", 64'(bus.in_mem_raddr), 64'd0);
    chk("rst waddr_wdata", 64'({bus.out_mem_waddr, bus.out_mem_wdata}), 64'd0);
    chk("rst perf", 64'(bus.perf_flops | bus.perf_mem_rd | bus.perf_mem_wr), 64'd0);
    rst_sys_n = 1'b1;

    // 4x4 ramp upscaled 2x
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r*4 + c] = ramp[c];
    run_job("ramp4x4", 4, 4, 16'h0200, 1'b0);
    nw = wd_q.size();
    if (nw > 7) begin
      chk("ramp out00", 64'(wd_q[0]), 64'd0);
      chk("ramp out01", 64'(wd_q[1]), 64'd50);
      chk("ramp out07", 64'(wd_q[7]), 64'd250);
    end else chk("ramp short", 64'(nw), 64'd64);

    // extra start edges mid-job and on the final WR are ignored
    run_job("ramp4x4_poke", 4, 4, 16'h0200, 1'b1);

    run_job("scale0", 4, 4, 0, 1'b0);
    run_job("too_big_in", 128, 64, 16'h0100, 1'b0);
    run_job("too_big_out", 4, 4, 16'hFF00, 1'b0);
    run_job("out_zero", 1, 1, 16'h0010, 1'b0);

    for (int k = 0; k < 3; k++) begin
      w  = int'($urandom_range(1, 9));
      h  = int'($urandom_range(1, 9));
      sc = int'($urandom_range(16'h0040, 16'h0300));
      for (int i = 0; i < w * h; i++) img[i] = 8'($urandom);
      run_job("random", w, h, sc, 1'b0);
    end

    for (int i = 0; i < 4096; i++) img[i] = 8'h5A;
    run_job("const64", 64, 64, 205, 1'b0);

    // reset in the middle of the second output row
    @(negedge clk_sys);
    bus.cfg_in_w = 16'd64;
    bus.cfg_in_h = 16'd64;
    bus.cfg_scale_q88 = 16'd205;
    bus.start = 1'b1;
    repeat (2) @(negedge clk_sys);
    bus.start = 1'b0;
    repeat (500) @(negedge clk_sys);
    chk("midrst busy_before", 64'(bus.status_busy), 64'd1);
    rst_sys_n = 1'b0;
    #1;
    chk("midrst status", 64'({bus.status_done, bus.status_busy, bus.status_error, bus.out_mem_we}), 64'd0);
    chk("midrst addrs", 64'({bus.in_mem_raddr, bus.out_mem_waddr, bus.out_mem_wdata}), 64'd0);
    chk("midrst perf", 64'(bus.perf_flops | bus.perf_mem_rd | bus.perf_mem_wr), 64'd0);
    nw = wa_q.size();
    repeat (4) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    repeat (4) @(negedge clk_sys);
    chk("midrst no_we", 64'(wa_q.size()), 64'(nw));
    chk("midrst idle", 64'({bus.status_done, bus.status_busy}), 64'd0);
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    run_job("post_reset", 8, 8, int'($urandom_range(16'h0080, 16'h0200)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
